// File: rtl/ram_dp_pkg.sv
// Shared types and default sizing for the byte-enable dual-port RAM.
package ram_dp_pkg;

  typedef enum logic {S_INIT, S_READY} state_e;

  localparam int DEP_DEF   = 64;
  localparam int WID_DEF   = 16;
  localparam int ADD_W_DEF = 6;

endpackage

// File: rtl/ram_dp_be_if.sv
// Access bus of ram_dp_be: one write port, one read port, status strobes.
interface ram_dp_be_if #(
  parameter int WID   = ram_dp_pkg::WID_DEF,
  parameter int ADD_W = ram_dp_pkg::ADD_W_DEF
) ();

  logic               busy;
  logic               wr_en;
  logic [ADD_W-1:0]   wr_addr;
  logic [WID-1:0]     wr_data;
  logic [WID/8-1:0]   wr_be;
  logic               rd_en;
  logic [ADD_W-1:0]   rd_addr;
  logic [WID-1:0]     rd_data;
  logic               rd_valid;
  logic               addr_err;

  modport master (
    input  busy, rd_data, rd_valid, addr_err,
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr
  );

  modport slave (
    output busy, rd_data, rd_valid, addr_err,
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr
  );

endinterface

// File: rtl/ram_dp_clr_fsm.sv
// Post-reset clear sequencer: walks every word once, writing zero, then
// releases the array for normal accesses.
module ram_dp_clr_fsm
  import ram_dp_pkg::*;
#(
  parameter int DEP   = DEP_DEF,
  parameter int ADD_W = ADD_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  output logic             busy_o,
  output logic             clr_we_o,
  output logic [ADD_W-1:0] clr_addr_o
);

  localparam logic [ADD_W-1:0] LAST = ADD_W'(DEP - 1);

  state_e           state_q, state_d;
  logic [ADD_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we_o = 1'b0;
    if (state_q == S_INIT) begin
      clr_we_o = 1'b1;
      if (cnt_q == LAST) begin
        state_d = S_READY;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign busy_o     = (state_q == S_INIT);
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/ram_dp_be.sv
// Simple dual-port RAM with per-byte write enables, write-first bypass on
// same-address collisions, optional extra output stage and post-reset clear.
module ram_dp_be
  import ram_dp_pkg::*;
#(
  parameter int DEP     = DEP_DEF,
  parameter int WID     = WID_DEF,
  parameter int ADD_W   = ADD_W_DEF,
  parameter int OUT_REG = 0
) (
  input  logic          clk,
  input  logic          rstn,
  ram_dp_be_if.slave    bus
);

  localparam int              NB     = WID / 8;
  localparam int              STAGES = (OUT_REG != 0) ? 1 : 0;
  localparam logic [ADD_W:0]  DEP_A  = (ADD_W + 1)'(DEP);

  if (WID % 8 != 0 || DEP < 2 || DEP > (1 << ADD_W)) begin : g_bad_param
    $error("ram_dp_be: illegal DEP/WID/ADD_W combination");
  end

  typedef struct packed {
    logic             en;
    logic [ADD_W-1:0] addr;
    logic [WID-1:0]   data;
    logic [NB-1:0]    be;
  } wr_req_t;

  logic             busy;
  logic             clr_we;
  logic [ADD_W-1:0] clr_addr;

  ram_dp_clr_fsm #(.DEP(DEP), .ADD_W(ADD_W)) u_clr (
    .clk        (clk),
    .rstn       (rstn),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  logic wr_in, rd_in, wr_ok, rd_ok, err_d, err_q;

  assign wr_in = ({1'b0, bus.wr_addr} < DEP_A);
  assign rd_in = ({1'b0, bus.rd_addr} < DEP_A);
  assign wr_ok = !busy && bus.wr_en && wr_in;
  assign rd_ok = !busy && bus.rd_en && rd_in;
  // Read and write faults in one cycle collapse into a single pulse.
  assign err_d = !busy && ((bus.wr_en && !wr_in) || (bus.rd_en && !rd_in));

  // Clear and user writes never overlap: user writes are gated by busy.
  wr_req_t mw;
  always_comb begin
    mw = '0;
    if (clr_we) begin
      mw.en   = 1'b1;
      mw.addr = clr_addr;
      mw.data = '0;
      mw.be   = '1;
    end else if (wr_ok) begin
      mw.en   = 1'b1;
      mw.addr = bus.wr_addr;
      mw.data = bus.wr_data;
      mw.be   = bus.wr_be;
    end
  end

  logic [WID-1:0] mem_q [DEP];

  always_ff @(posedge clk) begin
    if (mw.en) begin
      for (int b = 0; b < NB; b++) begin
        if (mw.be[b]) mem_q[mw.addr][8*b +: 8] <= mw.data[8*b +: 8];
      end
    end
  end

  // Write-first: enabled bytes of a same-address write override the stored word.
  logic           wr_hit;
  logic [WID-1:0] rd_word;

  assign wr_hit = wr_ok && (bus.wr_addr == bus.rd_addr);

  for (genvar b = 0; b < NB; b++) begin : g_byte
    assign rd_word[8*b +: 8] = (wr_hit && bus.wr_be[b]) ? bus.wr_data[8*b +: 8]
                                                        : mem_q[bus.rd_addr][8*b +: 8];
  end

  logic [STAGES:0] vld_pipe;
  logic [WID-1:0]  dat_pipe [STAGES:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe[0] <= 1'b0;
      dat_pipe[0] <= '0;
      err_q       <= 1'b0;
    end else begin
      vld_pipe[0] <= rd_ok;
      if (rd_ok) dat_pipe[0] <= rd_word;
      err_q <= err_d;
    end
  end

  // Later stages only advance on valid data so rd_data holds between reads.
  for (genvar s = 1; s <= STAGES; s++) begin : g_stage
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        vld_pipe[s] <= 1'b0;
        dat_pipe[s] <= '0;
      end else begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign bus.busy     = busy;
  assign bus.rd_valid = vld_pipe[STAGES];
  assign bus.rd_data  = dat_pipe[STAGES];
  assign bus.addr_err = err_q;

endmodule
